// File: rtl/mux4_arbiter.sv
// Round-robin arbiter driving the 2-bit select of a 4-input 32-bit mux, with valid/ready toward one consumer.
// Latency: request-to-grant 1 cycle; back-to-back transfers at one per cycle, no bubble on re-arbitration.
// Backpressure: while out_ready=0 the grant, select and out_valid hold; optional lock via MUX4_ARB_LOCK_EN.
module mux4_arbiter #(
  parameter int unsigned LOCK_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
`ifdef MUX4_ARB_LOCK_EN
  input  logic [3:0] lock,
`endif
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  // A lock budget outside 1..15 cannot be represented by the 4-bit counter.
  if (LOCK_MAX < 1 || LOCK_MAX > 15) begin : g_lock_max_range
    $error("mux4_arbiter: LOCK_MAX must be in 1..15");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] last_q, last_d;
  logic       relock;

`ifdef MUX4_ARB_LOCK_EN
  logic [3:0] lock_cnt_q, lock_cnt_d;
`endif

  // First set request searching upward from base+1 (mod 4); base itself is checked last.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = base;
    for (int k = 4; k >= 1; k--) begin
      idx = base + 2'(k);
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

  // Next-state: grant from idle, hold under backpressure, rotate (or relock) on handshake.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    relock  = 1'b0;
`ifdef MUX4_ARB_LOCK_EN
    lock_cnt_d = lock_cnt_q;
    relock = lock[sel_q] && req[sel_q] && (lock_cnt_q < 4'(LOCK_MAX - 1));
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          sel_d   = rr_pick(req, last_q);
          gnt_d   = 4'b0001 << sel_d;
`ifdef MUX4_ARB_LOCK_EN
          lock_cnt_d = 4'd0;
`endif
        end
      end
      GRANT: begin
        if (out_ready) begin
          if (relock) begin
            // Same owner keeps the mux; rotation pointer deliberately untouched.
`ifdef MUX4_ARB_LOCK_EN
            lock_cnt_d = lock_cnt_q + 4'd1;
`endif
          end else begin
            last_d = sel_q;
`ifdef MUX4_ARB_LOCK_EN
            lock_cnt_d = 4'd0;
`endif
            if (|req) begin
              sel_d = rr_pick(req, sel_q);
              gnt_d = 4'b0001 << sel_d;
            end else begin
              state_d = IDLE;
              sel_d   = 2'b00;
              gnt_d   = 4'b0000;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = 2'b00;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  // State and registered outputs; reset drops any in-flight transfer at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'b00;
      last_q  <= 2'b11;
`ifdef MUX4_ARB_LOCK_EN
      lock_cnt_q <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
`ifdef MUX4_ARB_LOCK_EN
      lock_cnt_q <= lock_cnt_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign out_valid = (state_q == GRANT);
  assign busy      = out_valid;

endmodule

// File: tb/tb_mux4_arbiter.sv
// Directed bench for mux4_arbiter with a scoreboard of expected transfer owners.
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
// A transfer is scored at the edge where out_valid and out_ready are both high.
module tb_mux4_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] lock;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic [31:0] mux_out;

  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0] exp_q[$];

  mux4_arbiter #(.LOCK_MAX(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
`ifdef MUX4_ARB_LOCK_EN
    .lock      (lock),
`endif
    .gnt       (gnt),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Behavioural 4:1 datapath mux, inputs A..D carry distinct words.
  function automatic logic [31:0] din(input logic [1:0] i);
    case (i)
      2'd0:    return 32'h0000_0001;
      2'd1:    return 32'h0000_0B0B;
      2'd2:    return 32'h00C0_C0C0;
      default: return 32'hD0D0_D0D0;
    endcase
  endfunction

  assign mux_out = din(sel);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_grant(input string tag, input logic [1:0] idx);
    chk({tag, "_gnt"}, 32'(gnt), 32'(4'b0001 << idx));
    chk({tag, "_sel"}, 32'(sel), 32'(idx));
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 32'd0);
    chk({tag, "_vld"}, 32'(out_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Score a handshake (if any) against the queue, then advance one clock.
  task automatic tick();
    logic [1:0] e;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      n_tests++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_underflow observed sel=%0d expected no transfer", sel);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_sel", 32'(sel), 32'(e));
        chk("sb_gnt", 32'(gnt), 32'(4'b0001 << e));
        chk("sb_data", mux_out, din(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    chk_idle("rst_async");
    chk("rst_sel", 32'(sel), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req = 4'b0000;
    lock = 4'b0000;
    out_ready = 1'b0;
    #2;
    chk_idle("reset");
    chk("reset_sel", 32'(sel), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: single request, one-cycle grant latency.
    req = 4'b0001;
    out_ready = 1'b1;
    exp_q.push_back(2'd0);
    tick();
    chk_grant("t1", 2'd0);
    chk("t1_data", mux_out, 32'h0000_0001);
    req = 4'b0000;
    tick();
    chk_idle("t1_end");
    chk("t1_drain", 32'(exp_q.size()), 32'd0);

    // 2: all requesting, full rotation with no bubble.
    pulse_reset();
    req = 4'b1111;
    tick();
    chk_grant("t2_first", 2'd0);
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    for (int i = 0; i < 5; i++) begin
      chk("t2_vld", 32'(out_valid), 32'd1);
      tick();
    end
    req = 4'b0000;
    tick();
    chk_idle("t2_end");
    chk("t2_drain", 32'(exp_q.size()), 32'd0);

    // 3: backpressure hold; owner drops req mid-hold without losing the grant.
    req = 4'b0100;
    out_ready = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      chk_grant("t3_hold", 2'd2);
      if (i == 2) req = 4'b0000;
      if (i < 5) tick();
    end
    out_ready = 1'b1;
    exp_q.push_back(2'd2);
    tick();
    chk_idle("t3_end");
    chk("t3_drain", 32'(exp_q.size()), 32'd0);

    // 4: reset mid-transfer, then priority restarts at requester 0.
    pulse_reset();
    req = 4'b1010;
    out_ready = 1'b0;
    tick();
    chk_grant("t4_pre", 2'd1);
    #1;
    pulse_reset();
    tick();
    chk_grant("t4_post", 2'd1);
    out_ready = 1'b1;
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd3);
    tick();
    chk_grant("t4_next", 2'd3);
    req = 4'b0000;
    tick();
    chk_idle("t4_end");
    chk("t4_drain", 32'(exp_q.size()), 32'd0);

    // 5/6: two requesters, requester 0 optionally locked.
    pulse_reset();
    req = 4'b0011;
    out_ready = 1'b1;
`ifdef MUX4_ARB_LOCK_EN
    lock = 4'b0001;
    tick();
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd0);
    for (int i = 0; i < 5; i++) tick();
    chk_grant("t5_relock", 2'd0);
    lock = 4'b0000;
`else
    tick();
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    for (int i = 0; i < 3; i++) tick();
    chk_grant("t6_alt", 2'd1);
`endif
    req = 4'b0000;
    tick();
    chk_idle("t56_end");
    chk("t56_drain", 32'(exp_q.size()), 32'd0);

    // 7: lone requester re-granted back-to-back.
    req = 4'b1000;
    tick();
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd3);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_grant("t7_b2b", 2'd3);
    end
    req = 4'b0000;
    tick();
    chk_idle("t7_end");
    chk("t7_drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
